// File: rtl/fixed_to_float_seq_if.sv
// fixed_to_float_seq_if: level enable/done request bus for the fixed->float converter
interface fixed_to_float_seq_if #(parameter int IN_WIDTH = 22);
  logic                enable;
  logic [IN_WIDTH-1:0] data;
  logic [31:0]         result;
  logic                done;
  modport master (output enable, data, input result, done);
  modport slave (input enable, data, output result, done);
endinterface

// File: rtl/fixed_to_float_seq.sv
// fixed_to_float_seq: sequential signed fixed-point to IEEE-754 single converter
module fixed_to_float_seq #(
  parameter int IN_WIDTH  = 22,
  parameter int FRAC_BITS = 20
) (
  input logic              clk,
  input logic              reset_n,
  fixed_to_float_seq_if.slave bus
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam int EB = 127 + IN_WIDTH - 1 - FRAC_BITS;
  typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;
  state_t              state, state_n;
  logic                sign, sign_n, zero, zero_n, done, done_n;
  logic [IN_WIDTH-1:0] mag, mag_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [31:0]         result, result_n;
  logic [7:0]          exp_v;
  logic [22:0]         man;
  // Normalisation shifts the leading one into the MSB, which becomes the hidden bit
  assign exp_v = 8'(EB) - 8'(cnt);
  assign man   = 23'(mag[IN_WIDTH-2:0]) << (24 - IN_WIDTH);
  always_comb begin
    state_n  = state;
    sign_n   = sign;
    zero_n   = zero;
    mag_n    = mag;
    cnt_n    = cnt;
    result_n = result;
    done_n   = done;
    case (state)
      IDLE: if (bus.enable) begin
        sign_n  = bus.data[IN_WIDTH-1];
        mag_n   = bus.data[IN_WIDTH-1] ? -bus.data : bus.data;
        zero_n  = bus.data == '0;
        cnt_n   = '0;
        state_n = NORM;
      end
      NORM: begin
        if (!bus.enable) state_n = IDLE;
        else if (zero || mag[IN_WIDTH-1]) state_n = PACK;
        else begin
          mag_n = mag << 1;
          cnt_n = cnt + CW'(1);
        end
      end
      PACK: begin
        if (!bus.enable) state_n = IDLE;
        else begin
          result_n = zero ? 32'h0 : {sign, exp_v, man};
          done_n   = 1'b1;
          state_n  = HOLD;
        end
      end
      default: if (!bus.enable) begin
        done_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      sign   <= 1'b0;
      zero   <= 1'b0;
      mag    <= '0;
      cnt    <= '0;
      result <= 32'h0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      sign   <= sign_n;
      zero   <= zero_n;
      mag    <= mag_n;
      cnt    <= cnt_n;
      result <= result_n;
      done   <= done_n;
    end
  end
  assign bus.result = result;
  assign bus.done   = done;
endmodule
